p2s: RTL and testbench

P2S -- requirements
Module: p2s

---
 rtl/p2s_pkg.sv | 21 ++
 rtl/p2s_buf.sv | 50 +++++
 rtl/p2s.sv | 170 +++++++++++++++++
 tb/tb_p2s.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// ---------------------------------------------------------------------------
// p2s_pkg -- shared definitions for the parallel-to-serial converter.
//
//   state_t    : serializer FSM states (IDLE / SHIFT / PARITY). PARITY is
//                only entered when the design is built with P2S_PARITY_EN.
//   cnt_width  : width of a counter that must hold the values 0..width.
// ---------------------------------------------------------------------------
package p2s_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // shift register empty
    SHIFT  = 2'd1,  // emitting data bits
    PARITY = 2'd2   // emitting the trailing even-parity bit
  } state_t;

  // Bits needed to count from 0 up to and including 'width'.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/p2s_buf.sv
// ---------------------------------------------------------------------------
// p2s_buf -- one-entry holding register between the producer and the
// shift register.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (entry becomes empty)
//   load       in   write load_data into the entry on this edge
//   load_data  in   [WIDTH] word to store
//   take       in   the consumer removes the stored word on this edge
//   full       out  the entry holds a word
//   data       out  [WIDTH] stored word
//
// load and take on the same edge is legal: the old word leaves and the new
// one takes its place, so the entry stays full.
// ---------------------------------------------------------------------------
module p2s_buf
  import p2s_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      // NOTE: the data register is cleared as well so a discarded word can
      // never leak out after reset; 'full' alone would be enough for
      // correctness, the clear just keeps the entry deterministic.
      data <= '0;
    end else begin
      if (load) begin
        data <= load_data;
      end
      if (load) begin
        full <= 1'b1;
      end else if (take) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/p2s.sv
// ---------------------------------------------------------------------------
// p2s -- parallel-to-serial converter with a one-word holding buffer.
//
// Parameters
//   WIDTH      parallel word width, 2..32
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   p2s_en         in   shift enable; low freezes shifting and buffer transfer
//   data_in        in   [WIDTH] parallel word
//   data_in_valid  in   data_in holds a valid word
//   data_in_ready  out  holding buffer is empty (combinational)
//   data_out       out  serial bit (registered, 0 when not valid)
//   data_out_valid out  data_out carries a bit this cycle (registered)
//   frame_start    out  first bit of a word (registered)
//
// Build option
//   P2S_PARITY_EN  when defined, each frame is followed by one even-parity
//                  bit (XOR of the word); otherwise a frame is WIDTH bits.
//
// A word accepted on edge N is moved into the shifter on edge N+1 (if the
// shifter is free) and its first bit is visible right after that edge. When
// the last bit of a frame completes and the buffer is full, the shifter
// reloads on the same edge, so back-to-back words stream with no gap.
// ---------------------------------------------------------------------------
module p2s
  import p2s_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p2s_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic             data_out,
  output logic             data_out_valid,
  output logic             frame_start
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] shreg;     // bits still to be sent, next one at the head
  logic [CNT_W-1:0] cnt;       // data bits of the current word already sent
`ifdef P2S_PARITY_EN
  logic             parity;    // even parity of the word in the shifter
`endif

  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic             load;
  logic             take;
  logic             frame_done;

  // Head of a word in transmit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the head bit so the next one moves into the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign data_in_ready = !buf_full;
  assign load          = data_in_valid && data_in_ready;

  // The edge that finishes the last serial bit of the current frame.
`ifdef P2S_PARITY_EN
  assign frame_done = (state == PARITY);
`else
  assign frame_done = (state == SHIFT) && (cnt == CNT_LAST);
`endif

  // Buffer-to-shifter transfer: shifter idle or just finishing a frame.
  assign take = p2s_en && buf_full && ((state == IDLE) || frame_done);

  p2s_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(data_in),
    .take     (take),
    .full     (buf_full),
    .data     (buf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      data_out       <= 1'b0;
      data_out_valid <= 1'b0;
      frame_start    <= 1'b0;
`ifdef P2S_PARITY_EN
      parity         <= 1'b0;
`endif
    end else if (!p2s_en) begin
      // Frozen: the position within the frame holds; the serial line shows
      // no bit, so data_out is parked at 0 alongside data_out_valid.
      data_out       <= 1'b0;
      data_out_valid <= 1'b0;
      frame_start    <= 1'b0;
    end else if (take) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values, e.g. buf_data is read before the buffer
      // updates on the same edge.
      state          <= SHIFT;
      shreg          <= advance(buf_data);
      cnt            <= CNT_ONE;
      data_out       <= head_bit(buf_data);
      data_out_valid <= 1'b1;
      frame_start    <= 1'b1;
`ifdef P2S_PARITY_EN
      parity         <= ^buf_data;
`endif
    end else begin
      frame_start <= 1'b0;
      case (state)
        SHIFT: begin
          if (cnt == CNT_LAST) begin
`ifdef P2S_PARITY_EN
            state          <= PARITY;
            cnt            <= '0;
            shreg          <= '0;
            data_out       <= parity;
            data_out_valid <= 1'b1;
`else
            // Last bit done and nothing buffered: go idle.
            state          <= IDLE;
            cnt            <= '0;
            shreg          <= '0;
            data_out       <= 1'b0;
            data_out_valid <= 1'b0;
`endif
          end else begin
            shreg          <= advance(shreg);
            cnt            <= cnt + CNT_ONE;
            data_out       <= head_bit(shreg);
            data_out_valid <= 1'b1;
          end
        end
`ifdef P2S_PARITY_EN
        PARITY: begin
          // Parity bit done and nothing buffered: go idle.
          state          <= IDLE;
          data_out       <= 1'b0;
          data_out_valid <= 1'b0;
        end
`endif
        default: begin
          state          <= IDLE;
          data_out       <= 1'b0;
          data_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s.sv
// ---------------------------------------------------------------------------
// tb_p2s -- self-checking bench for p2s (WIDTH=4, MSB_FIRST=1).
//
// Every accepted word is expanded into its expected serial frame (data bits
// in transmit order, plus the parity bit when P2S_PARITY_EN is defined) and
// appended to a queue; each cycle a valid serial bit must match the queue
// head, and an idle cycle must show data_out=0 and frame_start=0. Directed
// steps add exact-cycle expectations on top of that stream check.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_p2s;

  localparam int W         = 4;
  localparam bit MSB_FIRST = 1'b1;
`ifdef P2S_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         p2s_en;
  logic [W-1:0] data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic         data_out;
  logic         data_out_valid;
  logic         frame_start;

  exp_t exp_q[$];
  int   errors   = 0;
  int   total    = 0;
  bit   last_acc = 1'b0;

  p2s #(
    .WIDTH    (W),
    .MSB_FIRST(MSB_FIRST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .p2s_en        (p2s_en),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .frame_start   (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial frame for one word, straight from the frame definition.
  task automatic push_frame(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b  = MSB_FIRST ? w[W-1-i] : w[i];
      e.fs = (i == 0);
      exp_q.push_back(e);
    end
`ifdef P2S_PARITY_EN
    e.b  = ^w;
    e.fs = 1'b0;
    exp_q.push_back(e);
`endif
  endtask

  // One clock: note whether the current offer is accepted, advance to the
  // next falling edge, then check the serial output against the queue.
  task automatic tick();
    bit           acc;
    logic [W-1:0] w;
    exp_t         e;
    acc = data_in_valid && data_in_ready && !rst;
    w   = data_in;
    @(posedge clk);
    @(negedge clk);
    last_acc = acc;
    if (acc) push_frame(w);
    if (data_out_valid) begin
      if (exp_q.size() == 0) begin
        check("valid_with_nothing_pending", data_out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("stream_bit", data_out, e.b);
        check("stream_frame_start", frame_start, e.fs);
      end
    end else begin
      check("idle_data_out", data_out, 1'b0);
      check("idle_frame_start", frame_start, 1'b0);
    end
  endtask

  task automatic drain(input string tag);
    data_in_valid = 1'b0;
    p2s_en        = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && !data_out_valid) break;
      tick();
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_valid_low"}, data_out_valid, 1'b0);
  endtask

  initial begin
    bit w2_pending;

    rst           = 1'b1;
    p2s_en        = 1'b1;
    data_in       = '0;
    data_in_valid = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    check("rst_data_out", data_out, 1'b0);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_ready", data_in_ready, 1'b1);
    @(negedge clk);

    // ---- single word 1011: latency, 1/0/1/1, frame_start on first only ----
    data_in       = 4'b1011;
    data_in_valid = 1'b1;
    tick();
    check("single_accept", last_acc, 1'b1);
    data_in_valid = 1'b0;
    check("single_latency_gap", data_out_valid, 1'b0);
    check("single_ready_full", data_in_ready, 1'b0);
    tick();
    check("single_first_valid", data_out_valid, 1'b1);
    check("single_first_fs", frame_start, 1'b1);
    check("single_first_bit", data_out, 1'b1);
    for (int i = 1; i < FL; i++) begin
      tick();
      check("single_body_valid", data_out_valid, 1'b1);
    end
    tick();
    check("single_end_valid", data_out_valid, 1'b0);
    drain("single_drain");

    // ---- back-to-back 1011, 0110: contiguous 2*FL bits ----
    data_in       = 4'b1011;
    data_in_valid = 1'b1;
    tick();
    data_in    = 4'b0110;
    w2_pending = 1'b1;
    tick();
    for (int k = 0; k < 2 * FL; k++) begin
      check("b2b_contiguous", data_out_valid, 1'b1);
      if (k == 0 || k == FL) check("b2b_frame_start", frame_start, 1'b1);
      tick();
      if (w2_pending && last_acc) begin
        w2_pending    = 1'b0;
        data_in_valid = 1'b0;
      end
    end
    check("b2b_second_accepted", w2_pending, 1'b0);
    check("b2b_end_valid", data_out_valid, 1'b0);
    drain("b2b_drain");

    // ---- three words offered back to back: ready handshake ----
    data_in       = 4'b1001;
    data_in_valid = 1'b1;
    tick();                                   // word 1 accepted
    check("three_w1_acc", last_acc, 1'b1);
    data_in = 4'b0111;
    check("three_ready_after_w1", data_in_ready, 1'b0);
    tick();                                   // word 1 moves to shifter
    check("three_ready_free", data_in_ready, 1'b1);
    tick();                                   // word 2 accepted
    check("three_w2_acc", last_acc, 1'b1);
    data_in = 4'b1110;
    for (int i = 0; i < FL - 1; i++) begin
      check("three_ready_held_low", data_in_ready, 1'b0);
      tick();
      check("three_no_accept_while_full", last_acc, 1'b0);
    end
    check("three_ready_rises", data_in_ready, 1'b1);
    tick();                                   // word 3 accepted
    check("three_w3_acc", last_acc, 1'b1);
    data_in_valid = 1'b0;
    drain("three_drain");

    // ---- enable dropped for 3 cycles after bit 2 of 1100 ----
    data_in       = 4'b1100;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    tick();                                   // bit 1 visible
    tick();                                   // bit 2 visible
    check("en_bit2_valid", data_out_valid, 1'b1);
    p2s_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_low_valid", data_out_valid, 1'b0);
    end
    p2s_en = 1'b1;
    tick();
    check("en_resume_valid", data_out_valid, 1'b1);
    check("en_resume_bit3", data_out, 1'b0);
    tick();
    check("en_resume_bit4", data_out, 1'b0);
    drain("en_drain");

    // ---- reset mid-word with a second word buffered ----
    data_in       = 4'b1011;
    data_in_valid = 1'b1;
    tick();
    data_in = 4'b0001;
    tick();                                   // bit 1 of 1011
    tick();                                   // 0001 accepted, bit 2 shown
    check("rst_mid_buffered", last_acc, 1'b1);
    data_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_data_out", data_out, 1'b0);
    check("rst_mid_valid", data_out_valid, 1'b0);
    check("rst_mid_frame_start", frame_start, 1'b0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_ready", data_in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_mid_quiet", data_out_valid, 1'b0);
    end
    data_in       = 4'b0110;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    drain("rst_recover_drain");

    // ---- randomized traffic against the frame queue ----
    for (int c = 0; c < 400; c++) begin
      p2s_en        = ($urandom_range(0, 7) != 0);
      data_in_valid = ($urandom_range(0, 2) != 0);
      data_in       = W'($urandom);
      tick();
    end
    drain("random_drain");
    check("final_ready", data_in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
